// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Word-organised memory responder for the multi-cycle core's instruction
// fetch and load/store traffic. A request is accepted over a valid/ready
// request channel. The responder then waits a programmable number of cycles,
// performs the access and presents the result on a valid/ready response
// channel. The storage array M[] is not cleared by reset, so a bench can
// preload it hierarchically.
//
// Parameters:
//   DEPTH   - number of 32-bit words in M[] (power of two)
//   LATENCY - wait cycles between request acceptance and rsp_valid (0..15)
//   ADDR_W  - request byte-address width
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = in reset)
//   req_valid  in   request present
//   req_ready  out  responder can accept a request this cycle
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_be     in   byte enables for writes, bit i covers bits [8i+7:8i]
//   rsp_valid  out  response present
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  read data, 0 for writes and errored accesses
//   rsp_err    out  misaligned (or out-of-range) access
//
// Optional feature macro: MEM_RESPONDER_BOUNDS_CHECK_EN
//   Defined   : word addresses >= DEPTH are flagged with rsp_err and not
//               written.
//   Undefined : the word index is truncated, so accesses wrap modulo DEPTH.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0] M [DEPTH];

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_waitCnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_rspValid;
    logic [31:0]       r_rspRdata;
    logic              r_rspErr;

    logic              w_accept;
    logic              w_doAccess;
    logic              w_useReq;
    logic              w_accWe;
    logic [ADDR_W-1:0] w_accAddr;
    logic [31:0]       w_accWdata;
    logic [3:0]        w_accBe;
    logic [IDX_W-1:0]  w_index;
    logic              w_misaligned;
    logic              w_err;

    // Ready is forced low while reset is held so nothing is accepted in reset.
    assign req_ready = reset && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    // With LATENCY=0 the access happens on the accept edge itself, so the
    // operands come straight from the request bus rather than the latches.
    assign w_useReq   = (r_state == IDLE);
    assign w_accWe    = w_useReq ? req_we    : r_we;
    assign w_accAddr  = w_useReq ? req_addr  : r_addr;
    assign w_accWdata = w_useReq ? req_wdata : r_wdata;
    assign w_accBe    = w_useReq ? req_be    : r_be;

    assign w_index      = w_accAddr[IDX_W+1:2];
    assign w_misaligned = |w_accAddr[1:0];

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    // Any set bit above the index field means the word address is >= DEPTH.
    assign w_err = w_misaligned || (|w_accAddr[ADDR_W-1:IDX_W+2]);
`else
    // Upper address bits are ignored so that accesses wrap modulo DEPTH.
    logic w_unusedAddrHi;
    assign w_unusedAddrHi = ^w_accAddr[ADDR_W-1:IDX_W+2];
    assign w_err = w_misaligned;
`endif

    // Next-state logic. w_doAccess marks the edge that enters RESP.
    always_comb begin
        w_nextState = r_state;
        w_doAccess  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_nextState = RESP;
                        w_doAccess  = 1'b1;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_nextState = RESP;
                    w_doAccess  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, request latches, wait counter and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_waitCnt  <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'd0;
            r_rspErr   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_we      <= req_we;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_be      <= req_be;
                r_waitCnt <= LAT_M1;
            end else if ((r_state == WAIT) && (r_waitCnt != 4'd0)) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end
            if (w_doAccess) begin
                r_rspValid <= 1'b1;
                r_rspErr   <= w_err;
                r_rspRdata <= (!w_accWe && !w_err) ? M[w_index] : 32'd0;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rspValid <= 1'b0;
            end
        end
    end

    // Storage is deliberately outside the reset domain so preloaded contents
    // survive reset. Only enabled bytes of an error-free write are updated.
    always_ff @(posedge clk) begin
        if (w_doAccess && w_accWe && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_accBe[i]) begin
                    M[w_index][8*i +: 8] <= w_accWdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder. Two instances share the clock and reset:
// index 0 is built with LATENCY=1 and index 1 with LATENCY=3. Memories are
// preloaded hierarchically and every expected value is a hand-computed
// constant. The expected result for the out-of-range read depends on
// MEM_RESPONDER_BOUNDS_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        reqValid [2];
    logic        reqReady [2];
    logic        reqWe    [2];
    logic [31:0] reqAddr  [2];
    logic [31:0] reqWdata [2];
    logic [3:0]  reqBe    [2];
    logic        rspValid [2];
    logic        rspReady [2];
    logic [31:0] rspRdata [2];
    logic        rspErr   [2];

    int nChecks = 0;
    int nErrors = 0;

    mem_responder #(.DEPTH(1024), .LATENCY(1), .ADDR_W(32)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValid[0]),
        .req_ready (reqReady[0]),
        .req_we    (reqWe[0]),
        .req_addr  (reqAddr[0]),
        .req_wdata (reqWdata[0]),
        .req_be    (reqBe[0]),
        .rsp_valid (rspValid[0]),
        .rsp_ready (rspReady[0]),
        .rsp_rdata (rspRdata[0]),
        .rsp_err   (rspErr[0])
    );

    mem_responder #(.DEPTH(1024), .LATENCY(3), .ADDR_W(32)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValid[1]),
        .req_ready (reqReady[1]),
        .req_we    (reqWe[1]),
        .req_addr  (reqAddr[1]),
        .req_wdata (reqWdata[1]),
        .req_be    (reqBe[1]),
        .rsp_valid (rspValid[1]),
        .rsp_ready (rspReady[1]),
        .rsp_rdata (rspRdata[1]),
        .rsp_err   (rspErr[1])
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One full transaction on instance sel. Inputs change and outputs are
    // sampled on the falling edge. Latency is counted in cycles from the
    // accept cycle to the first cycle with rsp_valid high. The response is
    // held off for 'hold' cycles before rsp_ready is raised.
    task automatic applyStimulus(input int sel, input string tag,
                                 input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int hold,
                                 input logic [31:0] expData, input logic expErr);
        int          cyc;
        logic        readyLow;
        logic        stableOk;
        logic [31:0] firstData;
        @(negedge clk);
        checkOutput({tag, "_idleReady"}, {31'd0, reqReady[sel]}, 32'd1);
        reqValid[sel] = 1'b1;
        reqWe[sel]    = we;
        reqAddr[sel]  = addr;
        reqWdata[sel] = wdata;
        reqBe[sel]    = be;
        rspReady[sel] = 1'b0;
        @(negedge clk);
        reqValid[sel] = 1'b0;
        cyc      = 1;
        readyLow = 1'b1;
        while (!rspValid[sel] && cyc < 40) begin
            if (reqReady[sel]) readyLow = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (reqReady[sel]) readyLow = 1'b0;
        checkOutput({tag, "_latency"}, 32'(cyc), (sel == 0) ? 32'd2 : 32'd4);
        checkOutput({tag, "_readyLow"}, {31'd0, readyLow}, 32'd1);
        checkOutput({tag, "_rdata"}, rspRdata[sel], expData);
        checkOutput({tag, "_err"}, {31'd0, rspErr[sel]}, {31'd0, expErr});
        if (hold > 0) begin
            stableOk  = 1'b1;
            firstData = rspRdata[sel];
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rspValid[sel] || reqReady[sel] || rspRdata[sel] !== firstData
                    || rspErr[sel] !== expErr)
                    stableOk = 1'b0;
            end
            checkOutput({tag, "_stable"}, {31'd0, stableOk}, 32'd1);
        end
        rspReady[sel] = 1'b1;
        @(negedge clk);
        rspReady[sel] = 1'b0;
        checkOutput({tag, "_validDrop"}, {31'd0, rspValid[sel]}, 32'd0);
        checkOutput({tag, "_backIdle"}, {31'd0, reqReady[sel]}, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0;
            reqWe[i]    = 1'b0;
            reqAddr[i]  = 32'd0;
            reqWdata[i] = 32'd0;
            reqBe[i]    = 4'd0;
            rspReady[i] = 1'b0;
        end
        dut1.M[0] = 32'h00115093;
        dut1.M[1] = 32'd42;
        dut3.M[0] = 32'hA5A5A5A5;
        dut3.M[1] = 32'd42;
        dut3.M[2] = 32'h11223344;
        dut3.M[3] = 32'hCAFEF00D;

        #2;
        checkOutput("reset_ready1", {31'd0, reqReady[0]}, 32'd0);
        checkOutput("reset_valid1", {31'd0, rspValid[0]}, 32'd0);
        checkOutput("reset_ready3", {31'd0, reqReady[1]}, 32'd0);
        checkOutput("reset_valid3", {31'd0, rspValid[1]}, 32'd0);
        checkOutput("reset_rdata3", rspRdata[1], 32'd0);
        checkOutput("reset_err3", {31'd0, rspErr[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] basic read, LATENCY=1");
        applyStimulus(0, "rd0_lat1", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h00115093, 1'b0);

        $display("[TB] partial write then read, LATENCY=3");
        applyStimulus(1, "wr8", 1'b1, 32'h8, 32'hDEADBEEF, 4'b0011, 0, 32'h0, 1'b0);
        applyStimulus(1, "rd8", 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h1122BEEF, 1'b0);

        $display("[TB] back-pressure");
        applyStimulus(1, "rd4_hold", 1'b0, 32'h4, 32'h0, 4'h0, 5, 32'd42, 1'b0);

        $display("[TB] misaligned accesses");
        applyStimulus(1, "rd6_mis", 1'b0, 32'h6, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        applyStimulus(1, "wr3_mis", 1'b1, 32'h3, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
        applyStimulus(1, "rd0_after", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0);
        applyStimulus(1, "rd4_after", 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'd42, 1'b0);

        $display("[TB] zero byte-enable write");
        applyStimulus(0, "wr0_be0", 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0);
        applyStimulus(0, "rd0_be0", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h00115093, 1'b0);

        $display("[TB] out-of-range read");
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        applyStimulus(0, "rd1000", 1'b0, 32'h1000, 32'h0, 4'h0, 0, 32'h0, 1'b1);
`else
        applyStimulus(0, "rd1000", 1'b0, 32'h1000, 32'h0, 4'h0, 0, 32'h00115093, 1'b0);
`endif

        $display("[TB] reset during WAIT of a write");
        @(negedge clk);
        reqValid[1] = 1'b1;
        reqWe[1]    = 1'b1;
        reqAddr[1]  = 32'hC;
        reqWdata[1] = 32'h0;
        reqBe[1]    = 4'hF;
        @(negedge clk);
        reqValid[1] = 1'b0;
        checkOutput("rst_inWait", {31'd0, reqReady[1]}, 32'd0);
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_ready", {31'd0, reqReady[1]}, 32'd0);
        checkOutput("rst_valid", {31'd0, rspValid[1]}, 32'd0);
        checkOutput("rst_rdata", rspRdata[1], 32'd0);
        checkOutput("rst_err", {31'd0, rspErr[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, "rd12_rst", 1'b0, 32'hC, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised memory responder serving the multi-cycle core's instruction-fetch and load/store requests over a valid/ready request channel and a valid/ready response channel.
- Adds programmable wait states, so the control FSM's FETCH_WAIT and memory-wait states are exercised with latencies other than one cycle.
- Storage array M[] is directly preloadable by benches, as with the existing memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in M[]. Must be a power of two.
- LATENCY, 1, wait cycles between request acceptance and rsp_valid assertion. Range 0..15.
- ADDR_W, 32, request byte-address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  write data
- req_be  input  4  byte enables for writes; bit i covers bits [8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  32  read data; 0 for writes
- rsp_err  output  1  misaligned address (or out of range, see Optional Feature)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; req_ready=0 while reset is low; rsp_valid=0; rsp_rdata=0; rsp_err=0; wait counter=0.
  - M[] contents are not cleared.
  - Asserting reset mid-transaction aborts it; a pending write not yet committed is dropped.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/addr/wdata/be.
  - LATENCY=0: go to RESP.
  - Otherwise: load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to RESP.
- Entry to RESP (edge leaving IDLE or WAIT):
  - Perform the access and register the response.
  - Read: rsp_rdata=M[addr[log2(DEPTH)+1:2]].
  - Write: update only the bytes enabled by be; rsp_rdata=0.
  - rsp_valid=1.
- RESP:
  - req_ready=0.
  - Hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1.
  - Handshake cycle: go to IDLE; rsp_valid=0 next cycle.
  - A new request is not accepted in the same cycle as the response handshake.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- Total latency from accept edge to rsp_valid high: LATENCY+1 cycles.
- Misalignment: addr[1:0]!=0 sets rsp_err=1, suppresses the write, and gives rsp_rdata=0.
- be=0 write: completes normally, M[] unchanged, rsp_err=0.
- Read-after-write to the same word in back-to-back transactions returns the new data.
- rsp_ready held high while in IDLE/WAIT has no effect.

Optional Feature:
- Macro: MEM_RESPONDER_BOUNDS_CHECK_EN.
- Defined: addresses with addr[ADDR_W-1:2] >= DEPTH give rsp_err=1, rsp_rdata=0, and no write.
- Undefined: the word index is truncated to log2(DEPTH) bits, so accesses wrap modulo DEPTH. rsp_err then reflects misalignment only.

Test Plan:
- LATENCY=1, preload M[0]=32'h00115093; read addr 0 -> rsp_valid exactly 2 cycles after accept, rsp_rdata=32'h00115093, rsp_err=0.
- LATENCY=3; write addr 8, wdata 32'hDEADBEEF, be=4'b0011, M[2] preloaded 32'h11223344; then read addr 8 -> write response rdata=0; read returns 32'h1122BEEF; req_ready low for the 4 cycles between accept and rsp_valid.
- Back-pressure: read addr 4 (M[1]=42) with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata=42 stable throughout, req_ready=0; release -> IDLE next cycle.
- Misaligned read addr 6 and write addr 3 -> rsp_err=1, rsp_rdata=0, M[0] and M[1] unchanged.
- DEPTH=1024, read addr 32'h1000:
  - Macro defined: rsp_err=1.
  - Macro undefined: rsp_rdata=M[0].
- Reset pulled low during WAIT of a write to addr 12 -> outputs return to reset values immediately; M[3] unchanged; after release, a read of addr 12 returns the preloaded value.
